// File: rtl/draw_dispatcher.sv
// Draw dispatcher: turns one start pulse into a strided stream of primitive fetch
// requests and holds busy until every issued primitive has retired.
// Optional build macro DRAW_DISPATCH_PERF_EN adds busy/stall cycle counters.
module draw_dispatcher #(
    parameter int ADDR_W          = 32,
    parameter int COUNT_W         = 16,
    parameter int STRIDE          = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_base_addr,
    input  logic [COUNT_W-1:0] i_prim_count,
    output logic               o_busy,
    output logic               o_prim_valid,
    output logic [ADDR_W-1:0]  o_prim_addr,
    input  logic               i_prim_ready,
    input  logic               i_retire,
`ifdef DRAW_DISPATCH_PERF_EN
    output logic [31:0]        o_busy_cycles,
    output logic [31:0]        o_stall_cycles,
`endif
    output logic               o_err
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               hs;
    logic               retire_ok;
    logic               start_ok;

    assign hs        = valid_q & i_prim_ready;
    assign retire_ok = i_retire & (out_q != '0);
    assign start_ok  = i_start & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        out_d   = out_q + OUT_W'(hs) - OUT_W'(retire_ok);

        if (i_start && state_q != S_IDLE) begin
            err_d = 1'b1;
        end
        if (i_retire && out_q == '0) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    rem_d   = i_prim_count;
                    state_d = (i_prim_count != '0) ? S_ISSUE : S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    addr_d = addr_q + STRIDE_A;
                    rem_d  = rem_q - COUNT_W'(1);
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Uses the post-retire count so busy drops one cycle after the last retire.
                if (out_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Valid is derived from next-state values so it can be a registered output;
        // a pending request never retracts because rem/out only move on handshakes/retires.
        valid_d = (state_d == S_ISSUE) && (rem_d != '0) && (out_d < OUT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Start is folded in so the controller sees busy in the same cycle as its pulse.
    assign o_busy       = (state_q != S_IDLE) | i_start;
    assign o_prim_valid = valid_q;
    assign o_prim_addr  = addr_q;
    assign o_err        = err_q;

`ifdef DRAW_DISPATCH_PERF_EN
    logic [31:0] busy_cyc_q;
    logic [31:0] stall_cyc_q;
    logic        stall;

    assign stall = (valid_q & ~i_prim_ready) |
                   ((state_q == S_ISSUE) && (rem_q != '0) && (out_q >= OUT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else if (start_ok) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (state_q != S_IDLE && busy_cyc_q != '1) begin
                busy_cyc_q <= busy_cyc_q + 32'd1;
            end
            if (stall && stall_cyc_q != '1) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
        end
    end

    assign o_busy_cycles  = busy_cyc_q;
    assign o_stall_cycles = stall_cyc_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_draw_dispatcher.sv
// Bench for draw_dispatcher: table of draws checked against a scoreboard of expected
// fetch addresses, plus hand sequences for the outstanding limit, errors and reset.
module tb_draw_dispatcher;

    localparam int ADDR_W  = 32;
    localparam int COUNT_W = 16;
    localparam int STRIDE  = 32;
    localparam int MAXO    = 8;
    localparam int BOUND   = 4000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic [ADDR_W-1:0]  i_base_addr = '0;
    logic [COUNT_W-1:0] i_prim_count = '0;
    logic               o_busy;
    logic               o_prim_valid;
    logic [ADDR_W-1:0]  o_prim_addr;
    logic               i_prim_ready = 1'b0;
    logic               i_retire = 1'b0;
    logic               o_err;
`ifdef DRAW_DISPATCH_PERF_EN
    logic [31:0]        o_busy_cycles;
    logic [31:0]        o_stall_cycles;
`endif

    always #5 clk = ~clk;

    draw_dispatcher #(
        .ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .STRIDE(STRIDE), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_prim_count(i_prim_count),
        .o_busy(o_busy),
        .o_prim_valid(o_prim_valid),
        .o_prim_addr(o_prim_addr),
        .i_prim_ready(i_prim_ready),
        .i_retire(i_retire),
`ifdef DRAW_DISPATCH_PERF_EN
        .o_busy_cycles(o_busy_cycles),
        .o_stall_cycles(o_stall_cycles),
`endif
        .o_err(o_err)
    );

    int passed = 0;
    int total  = 0;
    logic [ADDR_W-1:0] exp_q[$];
    bit  sched[int];
    int  cyc = 0;
    int  launch_cyc = -1;
    int  out_model = 0;
    int  hs_total = 0;
    int  auto_delay = 0;
    int  ready_mode = 0;
    bit  mon_exp_valid;

    typedef struct {
        logic [31:0] base;
        int          count;
        int          rmode;
        int          delay;
        int          exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycle counter and retire driver, both moved 1 time unit after the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i_retire = rst_n && sched.exists(cyc);
        end
    end

    // Monitor at the falling edge: valid/address against the scoreboard and the
    // outstanding model, then apply this cycle's handshake and retire.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_model = 0;
            end else begin
                mon_exp_valid = (cyc > launch_cyc) && (exp_q.size() > 0) && (out_model < MAXO);
                check("prim_valid", {63'd0, o_prim_valid}, {63'd0, mon_exp_valid});
                if (o_prim_valid && exp_q.size() > 0)
                    check("prim_addr", {32'd0, o_prim_addr}, {32'd0, exp_q[0]});
                if (i_retire && out_model > 0) out_model--;
                if (o_prim_valid && i_prim_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_total++;
                    out_model++;
                    if (auto_delay > 0) sched[cyc + auto_delay] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (ready_mode != 0) i_prim_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic launch(input logic [31:0] base, input int count);
        i_start      = 1'b1;
        i_base_addr  = base;
        i_prim_count = COUNT_W'(count);
        for (int k = 0; k < count; k++) exp_q.push_back(base + 32'(k * STRIDE));
        launch_cyc = cyc;
        #1;
        check("busy_on_start", {63'd0, o_busy}, 64'd1);
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < BOUND) begin
            n++;
            step();
        end
        check("drain_in_bound", {63'd0, (n < BOUND)}, 64'd1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        exp_q.delete();
        sched.delete();
        out_model  = 0;
        auto_delay = 0;
        ready_mode = 0;
        #1;
        check({tag, "_busy"},  {63'd0, o_busy},       64'd0);
        check({tag, "_valid"}, {63'd0, o_prim_valid}, 64'd0);
        check({tag, "_err"},   {63'd0, o_err},        64'd0);
`ifdef DRAW_DISPATCH_PERF_EN
        check({tag, "_busy_cycles"},  {32'd0, o_busy_cycles},  64'd0);
        check({tag, "_stall_cycles"}, {32'd0, o_stall_cycles}, 64'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   h0;

        vecs[0] = '{32'h0000_1000,  3, 0,  2,  5};
        vecs[1] = '{32'h0000_0000,  0, 0,  2,  1};
        vecs[2] = '{32'hFFFF_FFC0,  5, 0,  1,  6};
        vecs[3] = '{32'h0000_4000, 12, 0,  5, 17};
        vecs[4] = '{32'h0000_8000, 16, 1,  1, -1};
        vecs[5] = '{32'h0000_A000, 24, 1, 20, -1};

        #1;
        check("rst_busy",  {63'd0, o_busy},       64'd0);
        check("rst_valid", {63'd0, o_prim_valid}, 64'd0);
        check("rst_addr",  {32'd0, o_prim_addr},  64'd0);
        check("rst_err",   {63'd0, o_err},        64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            ready_mode   = vecs[v].rmode;
            i_prim_ready = (vecs[v].rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            auto_delay   = vecs[v].delay;
            launch(vecs[v].base, vecs[v].count);
            wait_idle(n);
            if (vecs[v].exp_busy >= 0)
                check("draw_busy_cycles", 64'(n), 64'(vecs[v].exp_busy));
            check("draw_queue_empty", 64'(exp_q.size()), 64'd0);
            check("draw_err_clear", {63'd0, o_err}, 64'd0);
`ifdef DRAW_DISPATCH_PERF_EN
            if (vecs[v].exp_busy >= 0)
                check("perf_busy_cycles", {32'd0, o_busy_cycles}, 64'(vecs[v].exp_busy));
`endif
            $display("draw %0d base=0x%08h count=%0d busy_cycles=%0d", v, vecs[v].base,
                     vecs[v].count, n);
        end

        // Outstanding limit: no retires until 8 issue, then one more per retire.
        ready_mode   = 0;
        i_prim_ready = 1'b1;
        auto_delay   = 0;
        h0 = hs_total;
        launch(32'h0000_3000, 20);
        repeat (12) step();
        check("limit_first_burst", 64'(hs_total - h0), 64'd8);
        for (int r = 1; r <= 20; r++) begin
            sched[cyc + 1] = 1'b1;
            repeat (3) step();
            check("limit_refill", 64'(hs_total - h0), 64'((8 + r > 20) ? 20 : 8 + r));
        end
        wait_idle(n);
        check("limit_idle", {63'd0, o_busy}, 64'd0);
        check("limit_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("draw limit base=0x00003000 count=20 handshakes=%0d", hs_total - h0);

        // Start while busy: flagged, and the running draw keeps its address sequence.
        auto_delay = 2;
        launch(32'h0000_2000, 4);
        i_start      = 1'b1;
        i_base_addr  = 32'hDEAD_0000;
        i_prim_count = 16'd7;
        step();
        i_start = 1'b0;
        check("err_start_busy", {63'd0, o_err}, 64'd1);
        wait_idle(n);
        check("start_busy_cycles", 64'(n), 64'd5);
        check("start_busy_queue", 64'(exp_q.size()), 64'd0);
        $display("draw stray-start base=0x00002000 count=4 err=%0d", o_err);

        do_reset("reset_clear");

        // Retire while idle: flagged, and outstanding must not underflow.
        i_prim_ready = 1'b1;
        sched[cyc + 1] = 1'b1;
        step();
        step();
        check("err_retire_idle", {63'd0, o_err}, 64'd1);
        auto_delay = 2;
        launch(32'h0000_6000, 2);
        wait_idle(n);
        check("after_idle_retire_busy", 64'(n), 64'd4);
        $display("draw idle-retire base=0x00006000 count=2 busy_cycles=%0d", n);

        // Reset mid-issue with a pending request and a set error flag.
        ready_mode   = 0;
        i_prim_ready = 1'b0;
        auto_delay   = 0;
        launch(32'h0000_5000, 10);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        check("pre_reset_busy",  {63'd0, o_busy},       64'd1);
        check("pre_reset_valid", {63'd0, o_prim_valid}, 64'd1);
        check("pre_reset_err",   {63'd0, o_err},        64'd1);
        do_reset("mid_reset");

        i_prim_ready = 1'b1;
        auto_delay   = 2;
        launch(32'h0000_1000, 3);
        wait_idle(n);
        check("post_reset_busy_cycles", 64'(n), 64'd5);
        check("post_reset_queue", 64'(exp_q.size()), 64'd0);
        check("post_reset_err", {63'd0, o_err}, 64'd0);
`ifdef DRAW_DISPATCH_PERF_EN
        check("post_reset_perf_busy", {32'd0, o_busy_cycles}, 64'd5);
`endif
        $display("draw post-reset base=0x00001000 count=3 busy_cycles=%0d", n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
